stage_ex_mem: RTL and testbench
===============================

// Module: stage_ex_mem
// PURPOSE
//  Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the ID/EX
//  register outputs, performs the ALU operation, computes the branch target and destination
//  register, and registers results and the MEM/WB control bits for the MEM stage. Supports
//  stall (hold) and flush (bubble insert) from the hazard unit; 1-cycle latency.
// PARAMETERS
//  DATA_W   32  datapath width (register data, PC, immediate)
//  REG_AW   5   register-file address width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  i_stall        in   1       1 = hold every output register this cycle
//  i_flush        in   1       1 = load a bubble (priority over i_stall)
//  i_valid        in   1       1 = ID/EX holds a real instruction
//  i_read_rb_1    in   DATA_W  rs operand
//  i_read_rb_2    in   DATA_W  rt operand / store data
//  i_rt, i_rd     in   REG_AW  candidate destination registers
//  i_address_pc   in   DATA_W  PC+4 of the instruction
//  i_ext_sign     in   DATA_W  sign-extended immediate; [5:0] = funct for R-type
//  i_aluOp        in   3       ALU operation class (see BEHAVIOUR)
//  i_aluSrc       in   1       0 = operand B is rb_2, 1 = ext_sign
//  i_regDst       in   1       0 = write rt, 1 = write rd
//  i_branch, i_memRead, i_memWrite, i_regWrite, i_memToReg  in 1  pass-through controls
//  o_alu_result   out  DATA_W  registered ALU result
//  o_zero         out  1       registered (alu_result == 0)
//  o_branch_target out DATA_W  registered i_address_pc + (i_ext_sign << 2)
//  o_write_data   out  DATA_W  registered i_read_rb_2
//  o_write_reg    out  REG_AW  registered destination register
//  o_pc_src       out  1       registered i_branch & zero & i_valid
//  o_branch, o_memRead, o_memWrite, o_regWrite, o_memToReg  out 1  registered controls
//  o_valid        out  1       registered validity of the EX/MEM slot
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output = 0 immediately; held until rst_n rises.
//  - Combinational EX: B = i_aluSrc ? i_ext_sign : i_read_rb_2; A = i_read_rb_1.
//  - i_aluOp: 000 ADD, 001 SUB, 010 R-type by funct, 011 AND, 100 OR, 101 SLT, 110/111 result 0.
//  - Funct (aluOp=010): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT;
//    any other funct -> result 0.
//  - ADD/SUB wrap modulo 2^DATA_W, no overflow trap. SLT signed; result 1 or 0 zero-extended.
//  - Branch target: i_address_pc + {i_ext_sign[DATA_W-3:0],2'b00}, modulo 2^DATA_W.
//  - Write reg: i_regDst ? i_rd : i_rt.
//  - Per rising clk edge, priority: flush > stall > load.
//    flush: all outputs loaded with reset values (bubble, o_valid=0).
//    stall: all outputs keep previous values.
//    load:  results captured; if i_valid=0, o_branch/o_memRead/o_memWrite/o_regWrite/
//           o_memToReg/o_pc_src/o_valid forced 0, data fields captured as computed.
//  - Flush and stall together: flush wins. Reset mid-operation discards the slot.
//  - o_pc_src never asserts when i_valid=0 or i_branch=0.
// TESTING
//  - Reset: rst_n=0 mid-cycle -> all outputs 0 before next clk edge; stay 0 while low.
//  - R-type ADD: A=5, B(rb_2)=7, aluOp=010, funct=100000, regDst=1, rd=9 -> next edge
//    o_alu_result=12, o_write_reg=9, o_zero=0, o_valid=1.
//  - BEQ taken: A=B=0x1234, aluOp=001, branch=1, pc=0x100, imm=3 -> o_zero=1, o_pc_src=1,
//    o_branch_target=0x10C.
//  - SLT signed/wrap: A=0xFFFFFFFF, B=1, aluOp=101 -> 1; ADD 0xFFFFFFFF+1 -> 0, o_zero=1.
//  - Stall: load LW (memRead=1, result 0x40), then i_stall=1 two cycles with new inputs ->
//    outputs stay 0x40/memRead=1; stall=1 & flush=1 -> all controls 0, o_valid=0.
//  - Bubble: i_valid=0 with regWrite=1, branch=1, zero true -> o_regWrite=0, o_pc_src=0.

Source files
------------

// File: rtl/stage_ex_mem_if.sv
// Interface bundling the ID/EX-side inputs, hazard controls and EX/MEM-side
// outputs of the execute stage.
//   master : the upstream (ID/EX + hazard unit) view, drives the i_* signals
//            and observes the o_* signals
//   slave  : the execute stage view, consumes i_* and drives o_*
interface stage_ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // hazard control
  logic              i_stall;
  logic              i_flush;
  // ID/EX register contents
  logic              i_valid;
  logic [DATA_W-1:0] i_read_rb_1;
  logic [DATA_W-1:0] i_read_rb_2;
  logic [REG_AW-1:0] i_rt;
  logic [REG_AW-1:0] i_rd;
  logic [DATA_W-1:0] i_address_pc;
  logic [DATA_W-1:0] i_ext_sign;
  logic [2:0]        i_aluOp;
  logic              i_aluSrc;
  logic              i_regDst;
  logic              i_branch;
  logic              i_memRead;
  logic              i_memWrite;
  logic              i_regWrite;
  logic              i_memToReg;
  // EX/MEM register contents
  logic [DATA_W-1:0] o_alu_result;
  logic              o_zero;
  logic [DATA_W-1:0] o_branch_target;
  logic [DATA_W-1:0] o_write_data;
  logic [REG_AW-1:0] o_write_reg;
  logic              o_pc_src;
  logic              o_branch;
  logic              o_memRead;
  logic              o_memWrite;
  logic              o_regWrite;
  logic              o_memToReg;
  logic              o_valid;

  modport master (
    output i_stall, i_flush, i_valid, i_read_rb_1, i_read_rb_2, i_rt, i_rd,
           i_address_pc, i_ext_sign, i_aluOp, i_aluSrc, i_regDst, i_branch,
           i_memRead, i_memWrite, i_regWrite, i_memToReg,
    input  o_alu_result, o_zero, o_branch_target, o_write_data, o_write_reg,
           o_pc_src, o_branch, o_memRead, o_memWrite, o_regWrite, o_memToReg,
           o_valid
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_read_rb_1, i_read_rb_2, i_rt, i_rd,
           i_address_pc, i_ext_sign, i_aluOp, i_aluSrc, i_regDst, i_branch,
           i_memRead, i_memWrite, i_regWrite, i_memToReg,
    output o_alu_result, o_zero, o_branch_target, o_write_data, o_write_reg,
           o_pc_src, o_branch, o_memRead, o_memWrite, o_regWrite, o_memToReg,
           o_valid
  );
endinterface

// File: rtl/stage_ex_mem.sv
// Execute stage plus EX/MEM pipeline register of a 5-stage MIPS pipeline.
// Computes the ALU result, branch target and destination register from the
// ID/EX contents and registers them with the MEM/WB controls. One cycle of
// latency; the hazard unit may hold the register (stall) or load a bubble
// (flush, which wins over stall).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : stage_ex_mem_if.slave, i_* inputs from ID/EX and hazard unit,
//           o_* registered EX/MEM outputs
module stage_ex_mem #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  stage_ex_mem_if.slave  bus
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [2:0]               op,
    input logic [5:0]               funct,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: begin
        case (funct)
          6'b100000: r = a + b;
          6'b100010: r = a - b;
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          6'b100111: r = ~(a | b);
          6'b101010: r = (a < b) ? ONE : '0;
          default:   r = '0;
        endcase
      end
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = (a < b) ? ONE : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---- p0: combinational execute ----
  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic [DATA_W-1:0]        alu_p0;
  logic                     zero_p0;
  logic [DATA_W-1:0]        target_p0;
  logic [REG_AW-1:0]        wreg_p0;
  logic                     vld_p0;

  always_comb begin
    op_a_p0   = bus.i_read_rb_1;
    op_b_p0   = bus.i_aluSrc ? bus.i_ext_sign : bus.i_read_rb_2;
    alu_p0    = alu_calc(bus.i_aluOp, bus.i_ext_sign[5:0], op_a_p0, op_b_p0);
    zero_p0   = (alu_p0 == '0);
    target_p0 = bus.i_address_pc + {bus.i_ext_sign[DATA_W-3:0], 2'b00};
    wreg_p0   = bus.i_regDst ? bus.i_rd : bus.i_rt;
    vld_p0    = bus.i_valid;
  end

  // ---- p1: EX/MEM register ----
  logic [DATA_W-1:0] alu_p1;
  logic              zero_p1;
  logic [DATA_W-1:0] target_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [REG_AW-1:0] wreg_p1;
  logic              pc_src_p1;
  logic              branch_p1;
  logic              mem_rd_p1;
  logic              mem_wr_p1;
  logic              reg_wr_p1;
  logic              mem2reg_p1;
  logic              vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_p1     <= '0;
      zero_p1    <= 1'b0;
      target_p1  <= '0;
      wdata_p1   <= '0;
      wreg_p1    <= '0;
      pc_src_p1  <= 1'b0;
      branch_p1  <= 1'b0;
      mem_rd_p1  <= 1'b0;
      mem_wr_p1  <= 1'b0;
      reg_wr_p1  <= 1'b0;
      mem2reg_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (bus.i_flush) begin
      alu_p1     <= '0;
      zero_p1    <= 1'b0;
      target_p1  <= '0;
      wdata_p1   <= '0;
      wreg_p1    <= '0;
      pc_src_p1  <= 1'b0;
      branch_p1  <= 1'b0;
      mem_rd_p1  <= 1'b0;
      mem_wr_p1  <= 1'b0;
      reg_wr_p1  <= 1'b0;
      mem2reg_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (!bus.i_stall) begin
      // Data fields are captured even for a bubble; only the controls that
      // could change architectural state are gated by validity.
      alu_p1     <= alu_p0;
      zero_p1    <= zero_p0;
      target_p1  <= target_p0;
      wdata_p1   <= bus.i_read_rb_2;
      wreg_p1    <= wreg_p0;
      pc_src_p1  <= vld_p0 & bus.i_branch & zero_p0;
      branch_p1  <= vld_p0 & bus.i_branch;
      mem_rd_p1  <= vld_p0 & bus.i_memRead;
      mem_wr_p1  <= vld_p0 & bus.i_memWrite;
      reg_wr_p1  <= vld_p0 & bus.i_regWrite;
      mem2reg_p1 <= vld_p0 & bus.i_memToReg;
      vld_p1     <= vld_p0;
    end
  end

  assign bus.o_alu_result    = alu_p1;
  assign bus.o_zero          = zero_p1;
  assign bus.o_branch_target = target_p1;
  assign bus.o_write_data    = wdata_p1;
  assign bus.o_write_reg     = wreg_p1;
  assign bus.o_pc_src        = pc_src_p1;
  assign bus.o_branch        = branch_p1;
  assign bus.o_memRead       = mem_rd_p1;
  assign bus.o_memWrite      = mem_wr_p1;
  assign bus.o_regWrite      = reg_wr_p1;
  assign bus.o_memToReg      = mem2reg_p1;
  assign bus.o_valid         = vld_p1;

endmodule

// File: tb/tb_stage_ex_mem.sv
// Self-checking bench for stage_ex_mem: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the EX/MEM slot.
module tb_stage_ex_mem;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stage_ex_mem_if #(.DATA_W(32), .REG_AW(5)) bus ();

  stage_ex_mem #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] tgt;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        pc_src;
    logic        branch;
    logic        mrd;
    logic        mwr;
    logic        rwr;
    logic        m2r;
    logic        vld;
  } slot_t;

  slot_t exp_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%08h want=0x%08h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference ALU written from the operation table with plain integers.
  function automatic logic [31:0] ref_alu(input int op, input int funct,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2) begin
      if      (funct == 32) op = 0;
      else if (funct == 34) op = 1;
      else if (funct == 36) op = 3;
      else if (funct == 37) op = 4;
      else if (funct == 39) return ~(a | b);
      else if (funct == 42) op = 5;
      else return 32'd0;
    end
    if (op == 0) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
    if (op == 1) return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
    if (op == 3) return a & b;
    if (op == 4) return a | b;
    if (op == 5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic slot_t model_next(input slot_t cur);
    slot_t n;
    logic [31:0] b;
    logic v;
    if (bus.i_flush) return '0;
    if (bus.i_stall) return cur;
    b = bus.i_aluSrc ? bus.i_ext_sign : bus.i_read_rb_2;
    n.alu    = ref_alu(int'(bus.i_aluOp), int'(bus.i_ext_sign[5:0]), bus.i_read_rb_1, b);
    n.zero   = (n.alu == 32'd0);
    n.tgt    = 32'((longint'(bus.i_address_pc) + 4 * longint'(bus.i_ext_sign)) % 64'h1_0000_0000);
    n.wdata  = bus.i_read_rb_2;
    n.wreg   = bus.i_regDst ? bus.i_rd : bus.i_rt;
    v        = bus.i_valid;
    n.pc_src = v && bus.i_branch && n.zero;
    n.branch = v && bus.i_branch;
    n.mrd    = v && bus.i_memRead;
    n.mwr    = v && bus.i_memWrite;
    n.rwr    = v && bus.i_regWrite;
    n.m2r    = v && bus.i_memToReg;
    n.vld    = v;
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".alu"},    bus.o_alu_result,            exp_s.alu);
    chk({tag, ".zero"},   32'(bus.o_zero),             32'(exp_s.zero));
    chk({tag, ".tgt"},    bus.o_branch_target,         exp_s.tgt);
    chk({tag, ".wdata"},  bus.o_write_data,            exp_s.wdata);
    chk({tag, ".wreg"},   32'(bus.o_write_reg),        32'(exp_s.wreg));
    chk({tag, ".ctrl"},
        {25'd0, bus.o_pc_src, bus.o_branch, bus.o_memRead, bus.o_memWrite,
         bus.o_regWrite, bus.o_memToReg, bus.o_valid},
        {25'd0, exp_s.pc_src, exp_s.branch, exp_s.mrd, exp_s.mwr,
         exp_s.rwr, exp_s.m2r, exp_s.vld});
  endtask

  // Advance one clock: model computes the next slot, then outputs are sampled 1ns after the edge.
  task automatic step(input string tag);
    slot_t nxt;
    nxt = rst_n ? model_next(exp_s) : slot_t'('0);
    @(posedge clk);
    #1;
    exp_s = nxt;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.i_stall = 0; bus.i_flush = 0; bus.i_valid = 0;
    bus.i_read_rb_1 = 0; bus.i_read_rb_2 = 0; bus.i_rt = 0; bus.i_rd = 0;
    bus.i_address_pc = 0; bus.i_ext_sign = 0; bus.i_aluOp = 0; bus.i_aluSrc = 0;
    bus.i_regDst = 0; bus.i_branch = 0; bus.i_memRead = 0; bus.i_memWrite = 0;
    bus.i_regWrite = 0; bus.i_memToReg = 0;
  endtask

  task automatic rand_inputs();
    logic [5:0] fset [7];
    fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h11};
    bus.i_valid      = ($urandom_range(0, 7) != 0);
    bus.i_read_rb_1  = $urandom;
    bus.i_read_rb_2  = ($urandom_range(0, 3) == 0) ? bus.i_read_rb_1 : $urandom;
    bus.i_rt         = 5'($urandom);
    bus.i_rd         = 5'($urandom);
    bus.i_address_pc = $urandom;
    bus.i_ext_sign   = $urandom;
    if ($urandom_range(0, 1) == 1)
      bus.i_ext_sign[5:0] = fset[$urandom_range(0, 6)];
    bus.i_aluOp      = 3'($urandom);
    bus.i_aluSrc     = 1'($urandom);
    bus.i_regDst     = 1'($urandom);
    bus.i_branch     = 1'($urandom);
    bus.i_memRead    = 1'($urandom);
    bus.i_memWrite   = 1'($urandom);
    bus.i_regWrite   = 1'($urandom);
    bus.i_memToReg   = 1'($urandom);
    bus.i_stall      = ($urandom_range(0, 5) == 0);
    bus.i_flush      = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_s    = '0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // R-type ADD 5+7 into rd=9
    bus.i_valid = 1; bus.i_read_rb_1 = 5; bus.i_read_rb_2 = 7; bus.i_aluOp = 3'b010;
    bus.i_ext_sign = 32'h20; bus.i_regDst = 1; bus.i_rd = 9; bus.i_rt = 3; bus.i_regWrite = 1;
    step("radd");
    chk("radd.res", bus.o_alu_result, 32'd12);
    chk("radd.wreg", 32'(bus.o_write_reg), 32'd9);
    chk("radd.vld", 32'(bus.o_valid), 32'd1);

    // BEQ taken
    idle_inputs();
    bus.i_valid = 1; bus.i_read_rb_1 = 32'h1234; bus.i_read_rb_2 = 32'h1234;
    bus.i_aluOp = 3'b001; bus.i_branch = 1; bus.i_address_pc = 32'h100; bus.i_ext_sign = 3;
    step("beq");
    chk("beq.pcsrc", 32'(bus.o_pc_src), 32'd1);
    chk("beq.tgt", bus.o_branch_target, 32'h10C);

    // SLT signed: -1 < 1
    idle_inputs();
    bus.i_valid = 1; bus.i_read_rb_1 = 32'hFFFF_FFFF; bus.i_read_rb_2 = 1; bus.i_aluOp = 3'b101;
    step("slt");
    chk("slt.res", bus.o_alu_result, 32'd1);

    // ADD wrap to zero
    bus.i_aluOp = 3'b000;
    step("wrap");
    chk("wrap.res", bus.o_alu_result, 32'd0);
    chk("wrap.zero", 32'(bus.o_zero), 32'd1);

    // LW then stall two cycles with changing inputs
    idle_inputs();
    bus.i_valid = 1; bus.i_read_rb_1 = 32'h30; bus.i_ext_sign = 32'h10; bus.i_aluSrc = 1;
    bus.i_memRead = 1; bus.i_memToReg = 1; bus.i_regWrite = 1;
    step("lw");
    chk("lw.res", bus.o_alu_result, 32'h40);
    for (int k = 0; k < 2; k++) begin
      rand_inputs();
      bus.i_stall = 1; bus.i_flush = 0;
      step("stall");
      chk("stall.res", bus.o_alu_result, 32'h40);
      chk("stall.mrd", 32'(bus.o_memRead), 32'd1);
    end
    rand_inputs();
    bus.i_stall = 1; bus.i_flush = 1;
    step("flush");
    chk("flush.vld", 32'(bus.o_valid), 32'd0);
    chk("flush.mrd", 32'(bus.o_memRead), 32'd0);

    // Bubble with branch/regWrite asserted and zero result
    idle_inputs();
    bus.i_valid = 0; bus.i_regWrite = 1; bus.i_branch = 1; bus.i_aluOp = 3'b110;
    step("bubble");
    chk("bubble.rwr", 32'(bus.o_regWrite), 32'd0);
    chk("bubble.pcsrc", 32'(bus.o_pc_src), 32'd0);

    // Asynchronous reset mid-cycle after a real load
    idle_inputs();
    bus.i_valid = 1; bus.i_read_rb_1 = 32'h77; bus.i_regWrite = 1; bus.i_rt = 4;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    exp_s = '0;
    check_all("async_rst");
    step("rst_hold");
    #2;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
